// File: rtl/decoder_nbit_pulse_if.sv
// Handshake and output bundle for the timed one-hot decoder.
// The master side presents indices; the slave side is the decoder itself.
interface decoder_nbit_pulse_if #(
    parameter int N      = 3,
    parameter int HOLD_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      a;
    logic [HOLD_W-1:0] hold;
    logic              en;
    logic [2**N-1:0]   y;
    logic              busy;
    logic              done;

    modport master (
        output in_valid, a, hold, en,
        input  in_ready, y, busy, done
    );

    modport slave (
        input  in_valid, a, hold, en,
        output in_ready, y, busy, done
    );
endinterface

// File: rtl/decoder_nbit_pulse.sv
// Registered binary-to-one-hot decoder: each accepted index drives one bit of y
// for max(hold,1) enabled cycles, then y clears and done pulses.
module decoder_nbit_pulse #(
    parameter int N      = 3,
    parameter int HOLD_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    decoder_nbit_pulse_if.slave  bus
);
    localparam int W = 2**N;
    localparam logic [W-1:0]      ONE_Y   = W'(1);
    localparam logic [HOLD_W-1:0] ONE_CNT = HOLD_W'(1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t            r_state, w_state_nxt;
    logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]      r_idx, w_idx_nxt;
    logic [W-1:0]      r_y, w_y_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic              w_ready;
    logic              w_accept;
    logic [HOLD_W-1:0] w_hold_ld;
    logic [W-1:0]      w_y_new;
    logic [W-1:0]      w_y_idx;

    // Ready in IDLE, or on the final enabled cycle so a new index follows with no gap.
    assign w_ready   = (r_state == ST_IDLE) || (bus.en && (r_cnt == ONE_CNT));
    assign w_accept  = bus.in_valid && w_ready;
    assign w_hold_ld = (bus.hold == '0) ? ONE_CNT : bus.hold;
    assign w_y_new   = ONE_Y << bus.a;
    assign w_y_idx   = ONE_Y << r_idx;

    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_y_nxt     = r_y;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_y_nxt = '0;
                if (w_accept) begin
                    w_idx_nxt   = bus.a;
                    w_cnt_nxt   = w_hold_ld;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                    w_y_nxt     = bus.en ? w_y_new : '0;
                end
            end
            ST_ACTIVE: begin
                if (!bus.en) begin
                    w_y_nxt = '0;
                end else if (r_cnt == ONE_CNT) begin
                    w_done_nxt = 1'b1;
                    if (w_accept) begin
                        w_idx_nxt = bus.a;
                        w_cnt_nxt = w_hold_ld;
                        w_y_nxt   = w_y_new;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_y_nxt     = '0;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - ONE_CNT;
                    w_y_nxt   = w_y_idx;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.y        = r_y;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_decoder_nbit_pulse.sv
// Directed self-checking bench for decoder_nbit_pulse; expected values are
// hand-derived from the cycle behaviour of the decoder.
module tb_decoder_nbit_pulse;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    decoder_nbit_pulse_if #(.N(3), .HOLD_W(4)) bus ();

    decoder_nbit_pulse #(.N(3), .HOLD_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] y, input logic busy, input logic done);
        check({tag, ".y"},    32'(bus.y),    32'(y));
        check({tag, ".busy"}, 32'(bus.busy), 32'(busy));
        check({tag, ".done"}, 32'(bus.done), 32'(done));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.hold     = '0;
        bus.en       = 1'b1;

        // Reset state
        step();
        check_out("reset", 8'h00, 1'b0, 1'b0);
        check("reset.ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check_out("post_reset", 8'h00, 1'b0, 1'b0);

        // Single index a=3, hold=2
        bus.in_valid = 1'b1; bus.a = 3'd3; bus.hold = 4'd2;
        step();
        bus.in_valid = 1'b0;
        check_out("a3.c1", 8'h08, 1'b1, 1'b0);
        check("a3.c1.ready", 32'(bus.in_ready), 32'd0);
        step();
        check_out("a3.c2", 8'h08, 1'b1, 1'b0);
        check("a3.c2.ready", 32'(bus.in_ready), 32'd1);
        step();
        check_out("a3.end", 8'h00, 1'b0, 1'b1);
        step();
        check_out("a3.idle", 8'h00, 1'b0, 1'b0);

        // Sweep with hold=0 (treated as 1), back-to-back every cycle
        bus.in_valid = 1'b1; bus.hold = 4'd0;
        for (int i = 0; i < 8; i++) begin
            bus.a = 3'(i);
            step();
            check_out($sformatf("sweep%0d", i), 8'(1 << i), 1'b1, (i > 0));
            check($sformatf("sweep%0d.ready", i), 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check_out("sweep.end", 8'h00, 1'b0, 1'b1);
        step();

        // Pause: a=5, hold=4, en low for three edges after the second active cycle
        bus.in_valid = 1'b1; bus.a = 3'd5; bus.hold = 4'd4;
        step();
        bus.in_valid = 1'b0;
        check_out("pause.c1", 8'h20, 1'b1, 1'b0);
        step();
        check_out("pause.c2", 8'h20, 1'b1, 1'b0);
        bus.en = 1'b0;
        check("pause.ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("pause.off%0d", i), 8'h00, 1'b1, 1'b0);
        end
        bus.en = 1'b1;
        step();
        check_out("pause.c3", 8'h20, 1'b1, 1'b0);
        step();
        check_out("pause.c4", 8'h20, 1'b1, 1'b0);
        step();
        check_out("pause.end", 8'h00, 1'b0, 1'b1);
        step();

        // Asynchronous reset mid-hold: a=7, hold=15
        bus.in_valid = 1'b1; bus.a = 3'd7; bus.hold = 4'd15;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("rst.hold%0d", i), 8'h80, 1'b1, 1'b0);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check_out("rst.async", 8'h00, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        check("rst.ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("rst.quiet%0d", i), 8'h00, 1'b0, 1'b0);
        end

        // Ignored request while active: a=4 running, a=2 waits for in_ready
        bus.in_valid = 1'b1; bus.a = 3'd4; bus.hold = 4'd2;
        step();
        bus.a = 3'd2; bus.hold = 4'd1;
        check_out("ign.c1", 8'h10, 1'b1, 1'b0);
        check("ign.c1.ready", 32'(bus.in_ready), 32'd0);
        step();
        check_out("ign.c2", 8'h10, 1'b1, 1'b0);
        check("ign.c2.ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check_out("ign.a2", 8'h04, 1'b1, 1'b1);
        step();
        check_out("ign.end", 8'h00, 1'b0, 1'b1);
        step();

        // Back-to-back: a=1 hold=3, then a=6 hold=1 in the last active cycle
        bus.in_valid = 1'b1; bus.a = 3'd1; bus.hold = 4'd3;
        step();
        bus.in_valid = 1'b0;
        check_out("b2b.c1", 8'h02, 1'b1, 1'b0);
        step();
        check_out("b2b.c2", 8'h02, 1'b1, 1'b0);
        step();
        check_out("b2b.c3", 8'h02, 1'b1, 1'b0);
        bus.in_valid = 1'b1; bus.a = 3'd6; bus.hold = 4'd1;
        step();
        bus.in_valid = 1'b0;
        check_out("b2b.a6", 8'h40, 1'b1, 1'b1);
        step();
        check_out("b2b.end", 8'h00, 1'b0, 1'b1);
        step();
        check_out("b2b.idle", 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
